// File: rtl/exe_stage_alu.sv
// Execute-stage ALU with NZCV status register and EX/MEM pipeline register.
// One-cycle latency; supports hazard freeze and branch flush.
module exe_stage_alu #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [3:0]            exe_cmd,
    input  logic                  s_bit,
    input  logic [DATA_W-1:0]     val_1,
    input  logic [DATA_W-1:0]     val_2,
    input  logic [DATA_W-1:0]     st_val_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     st_val,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic                  valid_out,
    output logic [3:0]            status
);

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } alu_cmd_e;

    logic              is_sub;
    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic [DATA_W:0]   sum;
    logic              add_v;

    // Subtraction is a + ~b + cin, so the carry out is directly NOT borrow.
    assign is_sub  = (exe_cmd == CMD_SUB) || (exe_cmd == CMD_SBC);
    assign add_b   = is_sub ? ~val_2 : val_2;
    assign add_cin = (exe_cmd == CMD_ADD) ? 1'b0 :
                     (exe_cmd == CMD_SUB) ? 1'b1 : status[1];
    assign sum     = {1'b0, val_1} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
    assign add_v   = (val_1[DATA_W-1] == add_b[DATA_W-1]) &&
                     (sum[DATA_W-1] != val_1[DATA_W-1]);

    logic [DATA_W-1:0] res;
    logic              flag_c;
    logic              flag_v;
    logic              cmd_known;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        res       = '0;
        flag_c    = status[1];
        flag_v    = status[0];
        cmd_known = 1'b1;
        case (exe_cmd)
            CMD_MOV: res = val_2;
            CMD_MVN: res = ~val_2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                res    = sum[DATA_W-1:0];
                flag_c = sum[DATA_W];
                flag_v = add_v;
            end
            CMD_AND: res = val_1 & val_2;
            CMD_ORR: res = val_1 | val_2;
            CMD_EOR: res = val_1 ^ val_2;
            default: cmd_known = 1'b0;
        endcase
    end

    logic [3:0] nzcv;
    assign nzcv = {res[DATA_W-1], (res == '0), flag_c, flag_v};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            alu_result <= '0;
            st_val     <= '0;
            dest       <= '0;
            wb_en      <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            valid_out  <= 1'b0;
            status     <= 4'b0000;
        end else if (!freeze) begin
            if (flush) begin
                alu_result <= '0;
                st_val     <= '0;
                dest       <= '0;
                wb_en      <= 1'b0;
                mem_r_en   <= 1'b0;
                mem_w_en   <= 1'b0;
                valid_out  <= 1'b0;
            end else begin
                alu_result <= res;
                st_val     <= st_val_in;
                dest       <= dest_in;
                wb_en      <= wb_en_in & valid_in;
                mem_r_en   <= mem_r_en_in & valid_in;
                mem_w_en   <= mem_w_en_in & valid_in;
                valid_out  <= valid_in;
                if (valid_in && s_bit && cmd_known) begin
                    status <= nzcv;
                end
            end
        end
    end

endmodule
